// File: rtl/subservient_sram_arbiter.sv
// Shares one byte-wide SRAM between the SERV register file (absolute priority)
// and two 32-bit Wishbone ports, serialising each word access into four byte beats.
module subservient_sram_arbiter #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // register file port
  input  logic [aw-1:0] i_rf_waddr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_wen,
  input  logic [aw-1:0] i_rf_raddr,
  input  logic          i_rf_ren,
  output logic [7:0]    o_rf_rdata,
  // Wishbone port 0 (CPU data bus)
  input  logic [aw-3:0] i_wb0_adr,
  input  logic [31:0]   i_wb0_dat,
  input  logic [3:0]    i_wb0_sel,
  input  logic          i_wb0_we,
  input  logic          i_wb0_stb,
  output logic [31:0]   o_wb0_rdt,
  output logic          o_wb0_ack,
  // Wishbone port 1 (debug / loader)
  input  logic [aw-3:0] i_wb1_adr,
  input  logic [31:0]   i_wb1_dat,
  input  logic [3:0]    i_wb1_sel,
  input  logic          i_wb1_we,
  input  logic          i_wb1_stb,
  output logic [31:0]   o_wb1_rdt,
  output logic          o_wb1_ack,
  // SRAM
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [1:0]    bsel_q, bsel_d;
  logic          cap_q, cap_d;
  logic [1:0]    cap_idx_q, cap_idx_d;
  logic [23:0]   asm_q, asm_d;

  logic [aw-3:0] adr_g;
  logic [31:0]   dat_g;
  logic [3:0]    sel_g;
  logic          we_g;
  logic          rf_cycle;
  logic          beat;
  logic          ack0, ack1;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign rf_cycle = i_rf_wen | i_rf_ren;

  // Select the request fields of the latched grant
  always_comb begin
    if (grant_q) begin
      adr_g = i_wb1_adr;
      dat_g = i_wb1_dat;
      sel_g = i_wb1_sel;
      we_g  = i_wb1_we;
    end else begin
      adr_g = i_wb0_adr;
      dat_g = i_wb0_dat;
      sel_g = i_wb0_sel;
      we_g  = i_wb0_we;
    end
  end

  // Next-state, beat issue, read assembly and SRAM/ack outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    bsel_d       = bsel_q;
    cap_d        = 1'b0;
    cap_idx_d    = bsel_q;
    asm_d        = asm_q;
    beat         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    o_sram_waddr = i_rf_waddr;
    o_sram_wdata = i_rf_wdata;
    o_sram_wen   = i_rf_wen;
    o_sram_raddr = i_rf_raddr;

    // Byte read by the previous beat arrives now; byte 3 bypasses to rdt in ACK
    if (cap_q) begin
      case (cap_idx_q)
        2'd0:    asm_d[7:0]   = i_sram_rdata;
        2'd1:    asm_d[15:8]  = i_sram_rdata;
        2'd2:    asm_d[23:16] = i_sram_rdata;
        default: asm_d        = asm_q;
      endcase
    end else begin
      asm_d = asm_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_wb0_stb || i_wb1_stb) begin
          if (i_wb0_stb && i_wb1_stb) begin
            grant_d = rr_q;
          end else begin
            grant_d = i_wb1_stb;
          end
          bsel_d  = 2'd0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // A beat held off during reset keeps an abandoned write out of the SRAM
        if (!rf_cycle && !i_rst) begin
          beat         = 1'b1;
          o_sram_waddr = {adr_g, bsel_q};
          o_sram_raddr = {adr_g, bsel_q};
          o_sram_wdata = byte_of(dat_g, bsel_q);
          o_sram_wen   = we_g & sel_g[bsel_q];
          cap_d        = 1'b1;
          bsel_d       = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_ACK: begin
        ack0    = ~grant_q;
        ack1    = grant_q;
        rr_d    = ~grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      bsel_q    <= 2'd0;
      cap_q     <= 1'b0;
      cap_idx_q <= 2'd0;
      asm_q     <= 24'h000000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      bsel_q    <= bsel_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
      asm_q     <= asm_d;
    end
  end

  assign o_rf_rdata = i_sram_rdata;
  assign o_wb0_rdt  = {i_sram_rdata, asm_q};
  assign o_wb1_rdt  = {i_sram_rdata, asm_q};
  assign o_wb0_ack  = ack0;
  assign o_wb1_ack  = ack1;

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Directed bench for subservient_sram_arbiter: vector table of single-port
// transfers plus hand-written contention and reset-abort sequences.
module tb_subservient_sram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rf_waddr, i_rf_raddr, i_rf_wdata;
  logic        i_rf_wen, i_rf_ren;
  logic [7:0]  o_rf_rdata;
  logic [5:0]  i_wb0_adr, i_wb1_adr;
  logic [31:0] i_wb0_dat, i_wb1_dat;
  logic [3:0]  i_wb0_sel, i_wb1_sel;
  logic        i_wb0_we, i_wb1_we, i_wb0_stb, i_wb1_stb;
  logic [31:0] o_wb0_rdt, o_wb1_rdt;
  logic        o_wb0_ack, o_wb1_ack;
  logic [7:0]  o_sram_waddr, o_sram_wdata, o_sram_raddr;
  logic        o_sram_wen;
  logic [7:0]  sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];
  logic       mem_clr;

  always #5 i_clk = ~i_clk;

  subservient_sram_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rf_waddr(i_rf_waddr), .i_rf_wdata(i_rf_wdata), .i_rf_wen(i_rf_wen),
    .i_rf_raddr(i_rf_raddr), .i_rf_ren(i_rf_ren), .o_rf_rdata(o_rf_rdata),
    .i_wb0_adr(i_wb0_adr), .i_wb0_dat(i_wb0_dat), .i_wb0_sel(i_wb0_sel),
    .i_wb0_we(i_wb0_we), .i_wb0_stb(i_wb0_stb), .o_wb0_rdt(o_wb0_rdt), .o_wb0_ack(o_wb0_ack),
    .i_wb1_adr(i_wb1_adr), .i_wb1_dat(i_wb1_dat), .i_wb1_sel(i_wb1_sel),
    .i_wb1_we(i_wb1_we), .i_wb1_stb(i_wb1_stb), .o_wb1_rdt(o_wb1_rdt), .o_wb1_ack(o_wb1_ack),
    .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata), .o_sram_wen(o_sram_wen),
    .o_sram_raddr(o_sram_raddr), .i_sram_rdata(sram_rdata)
  );

  // SRAM model: synchronous write, one-cycle registered read
  always @(posedge i_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (o_sram_wen) begin
      mem[o_sram_waddr] <= o_sram_wdata;
    end
    sram_rdata <= mem[o_sram_raddr];
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [5:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] ren_pat;   // bit k: i_rf_ren in cycle k (cycle 0 = stb cycle)
    logic [31:0] wen_pat;
    int          exp_lat;   // cycle number of ack, stb cycle counted as 1
    logic [31:0] exp_rdt;
    logic [3:0]  exp_wmask; // beats that must write
    int          exp_span;  // cycles from first to last write beat, -1 = skip
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int          lat, first_k, last_k, idx;
    logic [31:0] rdt;
    logic [3:0]  wmask;
    bit          bad_rf, bad_beat, other, any_rf;
    lat = -1; first_k = -1; last_k = -1; rdt = 32'h0; wmask = 4'h0;
    bad_rf = 1'b0; bad_beat = 1'b0; other = 1'b0; any_rf = 1'b0;
    if (!v.port) begin
      i_wb0_adr = v.adr; i_wb0_dat = v.dat; i_wb0_sel = v.sel; i_wb0_we = v.we; i_wb0_stb = 1'b1;
    end else begin
      i_wb1_adr = v.adr; i_wb1_dat = v.dat; i_wb1_sel = v.sel; i_wb1_we = v.we; i_wb1_stb = 1'b1;
    end
    for (int k = 0; k < 32; k++) begin
      if (lat >= 0) break;
      i_rf_ren   = v.ren_pat[k];
      i_rf_wen   = v.wen_pat[k];
      i_rf_raddr = 8'hE0 + 8'(k);
      i_rf_waddr = 8'h40 + 8'(k);
      i_rf_wdata = 8'hA0 + 8'(k);
      @(negedge i_clk);
      if (i_rf_ren || i_rf_wen) begin
        any_rf = 1'b1;
        if (o_sram_raddr !== i_rf_raddr || o_sram_waddr !== i_rf_waddr ||
            o_sram_wdata !== i_rf_wdata || o_sram_wen !== i_rf_wen) bad_rf = 1'b1;
      end else if (o_sram_wen) begin
        idx = int'(o_sram_waddr[1:0]);
        if (o_sram_waddr[7:2] !== v.adr || o_sram_wdata !== v.dat[8*idx +: 8] ||
            !v.sel[idx] || !v.we) bad_beat = 1'b1;
        wmask[idx] = 1'b1;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (v.port ? o_wb0_ack : o_wb1_ack) other = 1'b1;
      if (v.port ? o_wb1_ack : o_wb0_ack) begin
        lat = k + 1;
        rdt = v.port ? o_wb1_rdt : o_wb0_rdt;
      end
      @(posedge i_clk); #1;
    end
    i_wb0_stb = 1'b0; i_wb1_stb = 1'b0; i_rf_ren = 1'b0; i_rf_wen = 1'b0;
    chk({tag, "_ack_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_wmask"}, {28'h0, wmask}, {28'h0, v.exp_wmask});
    chk({tag, "_beat_data"}, {31'h0, bad_beat}, 32'h0);
    chk({tag, "_other_ack"}, {31'h0, other}, 32'h0);
    if (any_rf) chk({tag, "_rf_follow"}, {31'h0, bad_rf}, 32'h0);
    if (!v.we) chk({tag, "_rdt"}, rdt, v.exp_rdt);
    if (v.exp_span >= 0) chk({tag, "_beat_span"}, 32'(last_k - first_k), 32'(v.exp_span));
    @(negedge i_clk);
    chk({tag, "_ack_single"}, {31'h0, (v.port ? o_wb1_ack : o_wb0_ack)}, 32'h0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    int          nack, first_ack_k;
    logic [3:0]  order;
    bit          both, bad;

    i_rst = 1'b1; mem_clr = 1'b1;
    i_rf_waddr = 8'h0; i_rf_raddr = 8'h0; i_rf_wdata = 8'h0; i_rf_wen = 1'b0; i_rf_ren = 1'b0;
    i_wb0_adr = 6'h0; i_wb0_dat = 32'h0; i_wb0_sel = 4'h0; i_wb0_we = 1'b0; i_wb0_stb = 1'b0;
    i_wb1_adr = 6'h0; i_wb1_dat = 32'h0; i_wb1_sel = 4'h0; i_wb1_we = 1'b0; i_wb1_stb = 1'b0;

    //          port  we    adr    dat           sel   ren_pat       wen_pat       lat  rdt           wmask span
    vecs[0] = '{1'b0, 1'b1, 6'h05, 32'hDDCCBBAA, 4'hF, 32'h0,        32'h0,        6,   32'h0,        4'hF, 3};
    vecs[1] = '{1'b0, 1'b0, 6'h05, 32'h0,        4'hF, 32'h0000000C, 32'h0,        8,   32'hDDCCBBAA, 4'h0, -1};
    vecs[2] = '{1'b1, 1'b1, 6'h0A, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h0,        6,   32'h0,        4'hF, 3};
    vecs[3] = '{1'b1, 1'b1, 6'h0A, 32'h44332211, 4'h5, 32'h0,        32'h0,        6,   32'h0,        4'h5, 2};
    vecs[4] = '{1'b0, 1'b0, 6'h0A, 32'h0,        4'hF, 32'h00000020, 32'h0,        6,   32'hFF33FF11, 4'h0, -1};
    vecs[5] = '{1'b1, 1'b0, 6'h05, 32'h0,        4'hF, 32'h00000011, 32'h0,        7,   32'hDDCCBBAA, 4'h0, -1};
    vecs[6] = '{1'b1, 1'b1, 6'h3F, 32'h01020304, 4'h8, 32'h0,        32'h0,        6,   32'h0,        4'h8, 0};
    vecs[7] = '{1'b1, 1'b0, 6'h05, 32'h0,        4'hF, 32'h0,        32'h000003FF, 15,  32'hDDCCBBAA, 4'h0, -1};
    vecs[8] = '{1'b0, 1'b0, 6'h3F, 32'h0,        4'hF, 32'h0,        32'h0,        6,   32'h01000000, 4'h0, -1};

    @(posedge i_clk); #1;
    mem_clr = 1'b0;
    @(negedge i_clk);
    chk("reset_ack0", {31'h0, o_wb0_ack}, 32'h0);
    chk("reset_ack1", {31'h0, o_wb1_ack}, 32'h0);
    chk("reset_wen", {31'h0, o_sram_wen}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("v%0d", i));

    // Contention from reset: rr was left on port 1, reset must return it to port 0
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_wb0_adr = 6'h05; i_wb0_we = 1'b0; i_wb0_sel = 4'hF; i_wb0_stb = 1'b1;
    i_wb1_adr = 6'h0A; i_wb1_we = 1'b0; i_wb1_sel = 4'hF; i_wb1_stb = 1'b1;
    nack = 0; order = 4'h0; both = 1'b0; first_ack_k = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge i_clk);
      if (o_wb0_ack && o_wb1_ack) both = 1'b1;
      if (o_wb0_ack || o_wb1_ack) begin
        if (first_ack_k < 0) first_ack_k = k;
        order = {order[2:0], o_wb1_ack};
        nack++;
        if (o_wb0_ack) chk("rr_rdt0", o_wb0_rdt, 32'hDDCCBBAA);
        else           chk("rr_rdt1", o_wb1_rdt, 32'hFF33FF11);
      end
      @(posedge i_clk); #1;
    end
    i_wb0_stb = 1'b0; i_wb1_stb = 1'b0;
    chk("rr_ack_count", 32'(nack), 32'd4);
    chk("rr_order", {28'h0, order}, 32'h5);
    chk("rr_first_ack_cycle", 32'(first_ack_k), 32'd5);
    chk("rr_both_acks", {31'h0, both}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1;

    // Reset during beat 2 of a port 1 write abandons the transfer
    i_wb1_adr = 6'h20; i_wb1_dat = 32'h88776655; i_wb1_sel = 4'hF; i_wb1_we = 1'b1; i_wb1_stb = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_wb0_ack || o_wb1_ack) bad = 1'b1;
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1; i_wb1_stb = 1'b0;
    @(negedge i_clk);
    chk("abort_wen_in_reset", {31'h0, o_sram_wen}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_wb0_ack || o_wb1_ack || o_sram_wen) bad = 1'b1;
      @(posedge i_clk); #1;
    end
    chk("abort_no_ack_no_write", {31'h0, bad}, 32'h0);
    chk("abort_mem80", {24'h0, mem[8'h80]}, 32'h55);
    chk("abort_mem81", {24'h0, mem[8'h81]}, 32'h66);
    chk("abort_mem82", {24'h0, mem[8'h82]}, 32'h00);
    chk("abort_mem83", {24'h0, mem[8'h83]}, 32'h00);
    v = '{1'b1, 1'b1, 6'h20, 32'h0D0C0B0A, 4'hF, 32'h0, 32'h0, 6, 32'h0, 4'hF, 3};
    run_xfer(v, "after_abort_wr");
    v = '{1'b1, 1'b0, 6'h20, 32'h0, 4'hF, 32'h0, 32'h0, 6, 32'h0D0C0B0A, 4'h0, -1};
    run_xfer(v, "after_abort_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
